multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle RISC_PROC datapath. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the datapath enables. It generates the 3-bit `aluOp` code consumed by the ALU control stage, and waits on a memory-ready handshake. It also keeps a wrapping retired-instruction counter for debug.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 4: instruction bits [15:12], valid from the instruction bus while in FETCH.
- `memReady` input 1: memory has completed the current read/write this cycle.
- `zero` input 1: ALU zero flag, sampled in EXEC for branches.
- `aluOp` output 3: 0=add, 1=subtract, 2=R-type (use func), 3=shift, 4=load-immediate pass.
- `aluSrcA` output 1: 0=PC, 1=register A.
- `aluSrcB` output 2: 0=register B, 1=constant 1, 2=sign-extended immediate.
- `pcWrite` output 1: PC load enable.
- `pcSrc` output 2: 0=ALU result, 1=branch target, 2=jump target.
- `irWrite` output 1: instruction-register load enable.
- `memRead` output 1: memory read strobe.
- `memWrite` output 1: memory write strobe.
- `iOrD` output 1: memory address select, 0=PC, 1=ALU out.
- `regWrite` output 1: register-file write enable.
- `memToReg` output 1: write-back source, 0=ALU out, 1=memory data.
- `halted` output 1: high while in HALT.
- `illegalOp` output 1: one-cycle pulse on an undefined opcode.
- `retired` output 16: count of completed instructions.

## Operation
- Opcode map: 0=R-type, 1=shift, 2=addi, 3=lw, 4=sw, 5=beq, 6=li, 7=jmp, F=halt. Opcodes 8–E are illegal.
- The `opcode` input is latched internally into `opReg` on the FETCH cycle in which `memReady`=1.
- Outputs are decoded combinationally from the state and `opReg`. Any output not listed for a state is 0.
- FETCH: `memRead`=1, `iOrD`=0, `aluSrcA`=0, `aluSrcB`=1, `aluOp`=0.
  - If `memReady`=1: also `irWrite`=1, `pcWrite`=1, `pcSrc`=0, and the next state is DECODE.
  - Otherwise the block stays in FETCH.
- DECODE: `aluSrcA`=0, `aluSrcB`=2, `aluOp`=0 (precomputes the branch target).
  - jmp: `pcWrite`=1, `pcSrc`=2, next state FETCH, retires.
  - halt: next state HALT, retires.
  - Illegal opcode: `illegalOp`=1, next state FETCH, does not retire.
  - All other opcodes: next state EXEC.
- EXEC: `aluSrcA`=1.
  - R-type: `aluOp`=2, `aluSrcB`=0, next state WB.
  - shift: `aluOp`=3, `aluSrcB`=0, next state WB.
  - addi/lw/sw: `aluOp`=0, `aluSrcB`=2. addi goes to WB; lw and sw go to MEM.
  - li: `aluOp`=4, `aluSrcB`=2, next state WB.
  - beq: `aluOp`=1, `aluSrcB`=0, `pcSrc`=1, `pcWrite`=`zero`, next state FETCH, retires.
- MEM: `iOrD`=1. lw asserts `memRead`=1; sw asserts `memWrite`=1.
  - Hold MEM until `memReady`=1. Then lw goes to WB; sw goes to FETCH and retires.
- WB: `regWrite`=1, `memToReg`=1 for lw and 0 otherwise. Next state FETCH, retires.
- HALT: all enables 0 and `halted`=1. Only reset leaves HALT.
- `retired` increments by 1 on the clock edge ending a retiring cycle. It wraps from FFFF to 0000.

## Timing
- Reset, asynchronous: state=FETCH, `opReg`=0, `retired`=0. Outputs immediately take the FETCH/`memReady`=0 decode: `memRead`=1, `aluSrcB`=1, every other output 0.
- Reset asserted mid-instruction aborts it. Enables drop to FETCH values in the same cycle, with no retire.
- Cycle counts with zero wait states:
  - jmp and halt: 2 cycles.
  - beq: 3 cycles.
  - R-type, shift, addi, li and sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `memReady`=0 in FETCH or MEM adds exactly one cycle.
- `memReady` is ignored in DECODE, EXEC, WB and HALT.
- `pcWrite` in beq EXEC is Mealy on `zero`, so `zero` must be settled before the clock edge.
- Illegal opcode: `illegalOp` is high for exactly one cycle, then the block refetches.

## Test plan
- Reset with `memReady`=1, opcode=0: FETCH→DECODE→EXEC(`aluOp`=2)→WB(`regWrite`=1)→FETCH. `retired`=1 after 4 cycles.
- lw with `memReady` low for 3 cycles in MEM: `memRead`=1 and `iOrD`=1 held for 4 cycles, then WB with `memToReg`=1. Total 8 cycles.
- beq with `zero`=1, then beq with `zero`=0: EXEC `aluOp`=1, `pcSrc`=1. `pcWrite`=1 for the first and 0 for the second. Each takes 3 cycles and retires.
- Opcode 8: DECODE pulses `illegalOp` for one cycle, returns to FETCH, `retired` unchanged. Next opcode 6 gives EXEC `aluOp`=4.
- Opcode F: enters HALT with `halted`=1, stays there for 20 cycles with all enables 0. `rst_n` low returns to FETCH with `retired`=0.
- Preload 65535 retirements and run one R-type: `retired` wraps to 0. Assert `rst_n` low mid-EXEC: outputs revert at once and `retired` clears.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC_PROC datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and ALU op codes, and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        memReady,
  input  logic        zero,
  output logic [2:0]  aluOp,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        irWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        iOrD,
  output logic        regWrite,
  output logic        memToReg,
  output logic        halted,
  output logic        illegalOp,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_SW    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_LI    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t      state;
  state_t      next_state;
  logic [3:0]  op_reg;
  logic [15:0] retired_cnt;
  logic        retire;
  logic        ready;

  // Opcodes that continue from DECODE into EXEC.
  function automatic logic goes_to_exec(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_SHIFT, OP_ADDI, OP_LW,
      OP_SW, OP_BEQ, OP_LI:              goes_to_exec = 1'b1;
      default:                           goes_to_exec = 1'b0;
    endcase
  endfunction

  // Masking with rst_n keeps the outputs at the FETCH/not-ready decode while reset is held.
  assign ready   = memReady & rst_n;
  assign retired = retired_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Instruction opcode capture on the completing fetch cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg <= 4'h0;
    end else if ((state == S_FETCH) && ready) begin
      op_reg <= opcode;
    end else begin
      op_reg <= op_reg;
    end
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= 16'h0000;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 16'h0001;
    end else begin
      retired_cnt <= retired_cnt;
    end
  end

  // Next-state, retire and datapath-control decode.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    aluOp      = 3'd0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'd0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    irWrite    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    iOrD       = 1'b0;
    regWrite   = 1'b0;
    memToReg   = 1'b0;
    halted     = 1'b0;
    illegalOp  = 1'b0;

    case (state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'd1;
        if (ready) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end

      S_DECODE: begin
        // PC + immediate is precomputed here as the branch target.
        aluSrcB = 2'd2;
        if (op_reg == OP_JMP) begin
          pcWrite    = 1'b1;
          pcSrc      = 2'd2;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (op_reg == OP_HALT) begin
          retire     = 1'b1;
          next_state = S_HALT;
        end else if (goes_to_exec(op_reg)) begin
          next_state = S_EXEC;
        end else begin
          illegalOp  = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_EXEC: begin
        aluSrcA = 1'b1;
        case (op_reg)
          OP_RTYPE: begin
            aluOp      = 3'd2;
            next_state = S_WB;
          end
          OP_SHIFT: begin
            aluOp      = 3'd3;
            next_state = S_WB;
          end
          OP_ADDI: begin
            aluSrcB    = 2'd2;
            next_state = S_WB;
          end
          OP_LW, OP_SW: begin
            aluSrcB    = 2'd2;
            next_state = S_MEM;
          end
          OP_LI: begin
            aluOp      = 3'd4;
            aluSrcB    = 2'd2;
            next_state = S_WB;
          end
          OP_BEQ: begin
            aluOp      = 3'd1;
            pcSrc      = 2'd1;
            pcWrite    = zero;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          default: begin
            next_state = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        iOrD = 1'b1;
        if (op_reg == OP_LW) begin
          memRead = 1'b1;
        end else begin
          memWrite = 1'b1;
        end
        if (ready) begin
          if (op_reg == OP_LW) begin
            next_state = S_WB;
          end else begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end else begin
          next_state = S_MEM;
        end
      end

      S_WB: begin
        regWrite   = 1'b1;
        memToReg   = (op_reg == OP_LW);
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end

      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step queues the expected control vector and
// retired count, then compares them against the DUT on the falling edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        memReady;
  logic        zero;
  logic [2:0]  aluOp;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        irWrite;
  logic        memRead;
  logic        memWrite;
  logic        iOrD;
  logic        regWrite;
  logic        memToReg;
  logic        halted;
  logic        illegalOp;
  logic [15:0] retired;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady), .zero(zero),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD),
    .regWrite(regWrite), .memToReg(memToReg), .halted(halted), .illegalOp(illegalOp),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // {aluOp, aluSrcA, aluSrcB, pcWrite, pcSrc, irWrite, memRead, memWrite, iOrD, regWrite, memToReg, halted, illegalOp}
  function automatic logic [16:0] ctl(input logic [2:0] aop, input logic sa, input logic [1:0] sb,
                                      input logic pw, input logic [1:0] ps, input logic irw,
                                      input logic mrd, input logic mwr, input logic iod,
                                      input logic rw, input logic m2r, input logic hlt, input logic ill);
    ctl = {aop, sa, sb, pw, ps, irw, mrd, mwr, iod, rw, m2r, hlt, ill};
  endfunction

  localparam logic [16:0] FETCH0  = ctl(3'd0, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] FETCH1  = ctl(3'd0, 1'b0, 2'd1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] DEC     = ctl(3'd0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] DEC_JMP = ctl(3'd0, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] DEC_ILL = ctl(3'd0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  localparam logic [16:0] EX_R    = ctl(3'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] EX_SH   = ctl(3'd3, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] EX_IMM  = ctl(3'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] EX_LI   = ctl(3'd4, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] EX_BEQ1 = ctl(3'd1, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] EX_BEQ0 = ctl(3'd1, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] MEM_LW  = ctl(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] MEM_SW  = ctl(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] WB_ALU  = ctl(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  localparam logic [16:0] WB_LW   = ctl(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  localparam logic [16:0] HALT    = ctl(3'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

  typedef struct {
    string       tag;
    logic [16:0] ctl_v;
    logic [15:0] ret_v;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] obs_ctl;
  logic [15:0] exp_ret;
  int          total = 0;
  int          bad   = 0;

  assign obs_ctl = {aluOp, aluSrcA, aluSrcB, pcWrite, pcSrc, irWrite, memRead, memWrite,
                    iOrD, regWrite, memToReg, halted, illegalOp};

  task automatic push_exp(input string tag, input logic [16:0] c);
    exp_t e;
    e.tag   = tag;
    e.ctl_v = c;
    e.ret_v = exp_ret;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      total++;
      assert (obs_ctl === e.ctl_v) else begin
        bad++;
        $error("FAIL %s ctl observed=%h expected=%h", e.tag, obs_ctl, e.ctl_v);
      end
      total++;
      assert (retired === e.ret_v) else begin
        bad++;
        $error("FAIL %s retired observed=%h expected=%h", e.tag, retired, e.ret_v);
      end
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at negedge, retire in the model after the edge.
  task automatic step(input string tag, input logic [3:0] op, input logic mr, input logic z,
                      input logic [16:0] c, input logic rets);
    opcode   = op;
    memReady = mr;
    zero     = z;
    push_exp(tag, c);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
    if (rets) exp_ret = exp_ret + 16'h0001;
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    exp_ret = 16'h0000;
    push_exp(tag, FETCH0);
    check_pop();
  endtask

  initial begin
    rst_n    = 1'b0;
    opcode   = 4'h0;
    memReady = 1'b1;
    zero     = 1'b0;
    exp_ret  = 16'h0000;
    #2;
    push_exp("reset", FETCH0);
    check_pop();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type
    step("r_fetch", 4'h0, 1'b1, 1'b0, FETCH1, 1'b0);
    step("r_dec",   4'hA, 1'b0, 1'b0, DEC,    1'b0);
    step("r_exec",  4'hB, 1'b1, 1'b0, EX_R,   1'b0);
    step("r_wb",    4'hC, 1'b0, 1'b0, WB_ALU, 1'b1);

    // lw with one fetch wait and three memory waits
    step("lw_fwait", 4'h3, 1'b0, 1'b0, FETCH0, 1'b0);
    step("lw_fetch", 4'h3, 1'b1, 1'b0, FETCH1, 1'b0);
    step("lw_dec",   4'h0, 1'b0, 1'b0, DEC,    1'b0);
    step("lw_exec",  4'h0, 1'b0, 1'b0, EX_IMM, 1'b0);
    for (int i = 0; i < 3; i++) step("lw_mwait", 4'h0, 1'b0, 1'b0, MEM_LW, 1'b0);
    step("lw_mem",   4'h0, 1'b1, 1'b0, MEM_LW, 1'b0);
    step("lw_wb",    4'h0, 1'b1, 1'b0, WB_LW,  1'b1);

    // beq taken then not taken
    step("beq1_fetch", 4'h5, 1'b1, 1'b0, FETCH1,  1'b0);
    step("beq1_dec",   4'h0, 1'b1, 1'b0, DEC,     1'b0);
    step("beq1_exec",  4'h0, 1'b0, 1'b1, EX_BEQ1, 1'b1);
    step("beq0_fetch", 4'h5, 1'b1, 1'b1, FETCH1,  1'b0);
    step("beq0_dec",   4'h0, 1'b1, 1'b1, DEC,     1'b0);
    step("beq0_exec",  4'h0, 1'b0, 1'b0, EX_BEQ0, 1'b1);

    // jmp, shift, addi, sw
    step("jmp_fetch", 4'h7, 1'b1, 1'b0, FETCH1,  1'b0);
    step("jmp_dec",   4'h0, 1'b0, 1'b0, DEC_JMP, 1'b1);
    step("sh_fetch",  4'h1, 1'b1, 1'b0, FETCH1,  1'b0);
    step("sh_dec",    4'h2, 1'b1, 1'b0, DEC,     1'b0);
    step("sh_exec",   4'h2, 1'b1, 1'b0, EX_SH,   1'b0);
    step("sh_wb",     4'h2, 1'b1, 1'b0, WB_ALU,  1'b1);
    step("addi_fetch",4'h2, 1'b1, 1'b0, FETCH1,  1'b0);
    step("addi_dec",  4'h3, 1'b1, 1'b0, DEC,     1'b0);
    step("addi_exec", 4'h3, 1'b1, 1'b0, EX_IMM,  1'b0);
    step("addi_wb",   4'h3, 1'b0, 1'b0, WB_ALU,  1'b1);
    step("sw_fetch",  4'h4, 1'b1, 1'b0, FETCH1,  1'b0);
    step("sw_dec",    4'h3, 1'b1, 1'b0, DEC,     1'b0);
    step("sw_exec",   4'h3, 1'b1, 1'b0, EX_IMM,  1'b0);
    step("sw_mwait",  4'h3, 1'b0, 1'b0, MEM_SW,  1'b0);
    step("sw_mem",    4'h3, 1'b1, 1'b0, MEM_SW,  1'b1);

    // illegal opcode then li
    step("ill_fetch", 4'h8, 1'b1, 1'b0, FETCH1,  1'b0);
    step("ill_dec",   4'h6, 1'b1, 1'b0, DEC_ILL, 1'b0);
    step("li_fetch",  4'h6, 1'b1, 1'b0, FETCH1,  1'b0);
    step("li_dec",    4'h8, 1'b1, 1'b0, DEC,     1'b0);
    step("li_exec",   4'h8, 1'b1, 1'b0, EX_LI,   1'b0);
    step("li_wb",     4'h8, 1'b1, 1'b0, WB_ALU,  1'b1);

    // counter wrap: preload 65535 retirements, then one R-type
    dut.retired_cnt = 16'hFFFF;
    exp_ret = 16'hFFFF;
    step("wrap_fetch", 4'h0, 1'b1, 1'b0, FETCH1, 1'b0);
    step("wrap_dec",   4'h0, 1'b1, 1'b0, DEC,    1'b0);
    step("wrap_exec",  4'h0, 1'b1, 1'b0, EX_R,   1'b0);
    step("wrap_wb",    4'h0, 1'b1, 1'b0, WB_ALU, 1'b1);
    step("wrap_after", 4'h7, 1'b1, 1'b0, FETCH1, 1'b0);
    step("jmp2_dec",   4'h0, 1'b1, 1'b0, DEC_JMP, 1'b1);

    // reset asserted mid-EXEC
    step("ab_fetch", 4'h0, 1'b1, 1'b0, FETCH1, 1'b0);
    step("ab_dec",   4'h0, 1'b1, 1'b0, DEC,    1'b0);
    reset_now("ab_reset");
    @(posedge clk);
    #1;
    push_exp("ab_reset_hold", FETCH0);
    check_pop();
    rst_n = 1'b1;

    // halt
    step("h_fetch", 4'hF, 1'b1, 1'b0, FETCH1, 1'b0);
    step("h_dec",   4'h0, 1'b1, 1'b0, DEC,    1'b1);
    for (int i = 0; i < 20; i++) step("h_hold", 4'h0, i[0], 1'b1, HALT, 1'b0);
    reset_now("h_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_fetch", 4'h0, 1'b1, 1'b0, FETCH1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
